// File: rtl/demux1_8.sv
// demux1_8: buffered 1-to-8 valid/ready stream demultiplexer with one-entry output registers.
// Routing is by external select or by an internal round-robin pointer. Rev 1.0
`default_nettype none

module demux1_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       s,
  input  logic             auto,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [2:0]       ptr
);

  logic [WIDTH-1:0] data_q [8];
  logic [2:0]       sel;
  logic             accept;

  assign sel      = auto ? ptr : s;
  // Only the selected channel gates acceptance; other channels never re-route.
  assign in_ready = !rst && (!out_valid[sel] || out_ready[sel]);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 8'h00;
      ptr       <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        // A fill takes priority over a drain, so drain+fill keeps valid high.
        if (accept && (sel == 3'(k))) begin
          data_q[k]    <= in;
          out_valid[k] <= 1'b1;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
      if (auto && accept) begin
        ptr <= ptr + 3'd1;
      end
    end
  end

  assign out1 = data_q[0];
  assign out2 = data_q[1];
  assign out3 = data_q[2];
  assign out4 = data_q[3];
  assign out5 = data_q[4];
  assign out6 = data_q[5];
  assign out7 = data_q[6];
  assign out8 = data_q[7];

endmodule

`default_nettype wire
